// File: rtl/afe_tot_multi_if.sv
// SPI readout bus of the AFE time-over-threshold digitiser.
// The CPLD is the SPI slave; the readout controller is the master.
interface afe_tot_multi_if;
    logic CS_B;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output CS_B, output SCLK, output MOSI, input MISO);
    modport slave  (input CS_B, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/afe_tot_multi.sv
// N-channel time-over-threshold digitiser with SPI-slave readout.
// An injection edge arms every enabled channel; each channel then counts
// CLK cycles while its synchronised discriminator output is high.  Results
// are held until a complete SPI frame reads them out and clears them.
module afe_tot_multi #(
    parameter int unsigned       N_CH    = 4,
    parameter int unsigned       CNT_W   = 8,
    parameter int unsigned       TIMEOUT = 64,
    parameter logic [N_CH-1:0]   MASK0   = '1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            INJ_IN,
    input  logic [N_CH-1:0] COMP,
    output logic [N_CH-1:0] HIT,
    output logic            RDY,
    afe_tot_multi_if.slave  spi
);

    localparam int unsigned FRAME = N_CH + N_CH * CNT_W;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned BC_W  = $clog2(FRAME + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COUNT,
        ST_DONE
    } chan_state_t;

    // Synchroniser chains: [0] first flop, [1] synchronised value, [2] previous value.
    logic [2:0]      inj_sr;
    logic [2:0]      cs_sr;
    logic [2:0]      sclk_sr;
    logic [1:0]      mosi_sr;
    logic [N_CH-1:0] comp_s1;
    logic [N_CH-1:0] comp_s2;
    logic [N_CH-1:0] comp_s3;

    logic            inj_rise;
    logic            cs_fall;
    logic            cs_rise;
    logic            sclk_rise;
    logic            sclk_fall;
    logic [N_CH-1:0] comp_rise;
    logic [N_CH-1:0] comp_fall;

    // Shared channel / readout signals.
    logic [N_CH-1:0]  mask_q;
    logic [N_CH-1:0]  done_vec;
    logic [N_CH-1:0]  clr_vec;
    logic [FRAME-1:0] snapshot;

    // SPI frame state.
    logic             frame_active;
    logic [BC_W-1:0]  bitcnt_q;
    logic [N_CH-1:0]  rx_q;
    logic [N_CH-1:0]  snap_done_q;
    logic [FRAME-1:0] shreg_q;
    logic             miso_q;

    // Two-flop synchronisers plus one delayed copy for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            inj_sr  <= '0;
            comp_s1 <= '0;
            comp_s2 <= '0;
            comp_s3 <= '0;
            // The select chain resets low so that a CS_B held low through reset
            // never looks like a falling edge; a frame needs a fresh high-to-low.
            cs_sr   <= '0;
            sclk_sr <= '0;
            mosi_sr <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values,
            // independent of statement order inside the block.
            inj_sr  <= {inj_sr[1:0], INJ_IN};
            comp_s1 <= COMP;
            comp_s2 <= comp_s1;
            comp_s3 <= comp_s2;
            cs_sr   <= {cs_sr[1:0], spi.CS_B};
            sclk_sr <= {sclk_sr[1:0], spi.SCLK};
            mosi_sr <= {mosi_sr[0], spi.MOSI};
        end
    end

    assign inj_rise  = inj_sr[1] & ~inj_sr[2];
    assign cs_fall   = ~cs_sr[1] & cs_sr[2];
    assign cs_rise   = cs_sr[1] & ~cs_sr[2];
    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign comp_rise = comp_s2 & ~comp_s3;
    assign comp_fall = ~comp_s2 & comp_s3;

    // A completed frame releases exactly the channels that were DONE when it started.
    assign clr_vec = (frame_active && cs_rise && (bitcnt_q >= BC_W'(FRAME))) ? snap_done_q : '0;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        chan_state_t      state_q;
        chan_state_t      state_d;
        chan_state_t      cur_state;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [TMO_W-1:0] tmo_q;
        logic [TMO_W-1:0] tmo_d;

        // Read-clear is applied before the FSM so an injection in the same cycle re-arms.
        assign cur_state = clr_vec[g] ? ST_IDLE : state_q;

        // Channel state, TOT count and timeout registers.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                tmo_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                tmo_q   <= tmo_d;
            end
        end

        // Next state: mask disable wins, otherwise the TOT FSM from the post-clear state.
        always_comb begin
            // NOTE: every output gets a default first, so no path leaves one
            // unassigned and no latch is inferred.
            state_d = cur_state;
            cnt_d   = clr_vec[g] ? '0 : cnt_q;
            tmo_d   = tmo_q;
            if (!mask_q[g]) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tmo_d   = '0;
            end else begin
                case (cur_state)
                    ST_IDLE: begin
                        if (inj_rise) begin
                            state_d = ST_ARMED;
                            cnt_d   = '0;
                            tmo_d   = TMO_W'(TIMEOUT);
                        end
                    end
                    ST_ARMED: begin
                        if (comp_rise[g]) begin
                            state_d = ST_COUNT;
                            cnt_d   = CNT_W'(1);
                        end else if (tmo_q <= TMO_W'(1)) begin
                            state_d = ST_DONE;
                            cnt_d   = '0;
                            tmo_d   = '0;
                        end else begin
                            tmo_d = tmo_q - 1'b1;
                        end
                    end
                    ST_COUNT: begin
                        if (comp_fall[g]) begin
                            state_d = ST_DONE;
                        end else if (comp_s2[g] && (cnt_q != '1)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_d = ST_DONE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign done_vec[g] = (state_q == ST_DONE);
        assign snapshot[FRAME-1-N_CH-g*CNT_W -: CNT_W] = cnt_q;
    end

    assign snapshot[FRAME-1 -: N_CH] = done_vec;

    assign HIT = comp_s2 & mask_q;
    assign RDY = (mask_q != '0) && (&(done_vec | ~mask_q));

    // Frame control: snapshot on select, shift on synced SCLK edges, commit on deselect.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_active <= 1'b0;
            bitcnt_q     <= '0;
            rx_q         <= '0;
            snap_done_q  <= '0;
            shreg_q      <= '0;
            miso_q       <= 1'b0;
            mask_q       <= MASK0;
        end else if (!frame_active) begin
            miso_q <= 1'b0;
            if (cs_fall) begin
                frame_active <= 1'b1;
                bitcnt_q     <= '0;
                rx_q         <= '0;
                snap_done_q  <= done_vec;
                miso_q       <= snapshot[FRAME-1];
                shreg_q      <= {snapshot[FRAME-2:0], 1'b0};
            end
        end else if (cs_rise) begin
            frame_active <= 1'b0;
            miso_q       <= 1'b0;
            if (bitcnt_q >= BC_W'(N_CH)) begin
                mask_q <= rx_q;
            end
        end else begin
            if (sclk_rise) begin
                rx_q <= (rx_q << 1) | N_CH'(mosi_sr[1]);
                if (bitcnt_q != '1) begin
                    bitcnt_q <= bitcnt_q + 1'b1;
                end
            end
            if (sclk_fall) begin
                miso_q  <= shreg_q[FRAME-1];
                shreg_q <= {shreg_q[FRAME-2:0], 1'b0};
            end
        end
    end

    assign spi.MISO = miso_q;

endmodule
